// File: rtl/sort_pkg.sv
// Shared definitions for the step-by-step insertion sort controller.
// Holds size defaults, index/count widths and the controller state encoding.
package sort_pkg;

  localparam int N_DEFAULT = 8;
  localparam int W_DEFAULT = 8;
  localparam int IDX_W     = $clog2(N_DEFAULT);
  localparam int CNT_W     = 6;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD_KEY,
    COMPARE,
    INSERT,
    DONE
  } state_t;

  // Counters stick at all-ones so larger arrays never wrap back to small values
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sort_regfile.sv
// Element storage for the sorter: N x W flops with one write port and
// combinational reads of A[h-1], A[i] and the display address.
module sort_regfile #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                 clk_100mhz,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [$clog2(N)-1:0] i_waddr,
  input  logic [W-1:0]         i_wdata,
  input  logic [$clog2(N)-1:0] i_holeAddr,
  input  logic [$clog2(N)-1:0] i_keyAddr,
  input  logic [$clog2(N)-1:0] i_rdAddr,
  output logic [W-1:0]         o_prevData,
  output logic [W-1:0]         o_keyData,
  output logic [W-1:0]         o_rdData
);

  localparam int IW = $clog2(N);

  logic [W-1:0]  r_mem [N];
  logic [IW-1:0] w_prevAddr;

  // h-1 wraps when h=0; the controller never acts on that read
  assign w_prevAddr = i_holeAddr - 1'b1;

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_prevData = r_mem[w_prevAddr];
  assign o_keyData  = r_mem[i_keyAddr];
  assign o_rdData   = r_mem[i_rdAddr];

endmodule

// File: rtl/sort_step_controller.sv
// Insertion sort that advances one algorithm step per ce_step pulse so the
// progress can be watched on a slow display; counts comparisons and shifts.
module sort_step_controller
  import sort_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic                 clk_100mhz,
  input  logic                 reset,
  input  logic                 ce_step,
  input  logic                 start,
  input  logic                 load_we,
  input  logic [$clog2(N)-1:0] load_addr,
  input  logic [W-1:0]         load_data,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [W-1:0]         rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] key_idx,
  output logic [$clog2(N)-1:0] hole_idx,
  output logic [W-1:0]         key,
  output logic [CNT_W-1:0]     cmp_count,
  output logic [CNT_W-1:0]     shift_count
);

  localparam int IW = $clog2(N);

  state_t           r_state;
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    r_h;
  logic [W-1:0]     r_key;
  logic [CNT_W-1:0] r_cmp;
  logic [CNT_W-1:0] r_shift;
  logic             r_busy;
  logic             r_done;

  logic             w_we;
  logic [IW-1:0]    w_waddr;
  logic [W-1:0]     w_wdata;
  logic [W-1:0]     w_prevData;
  logic [W-1:0]     w_keyData;
  logic             w_doShift;

  sort_regfile #(
    .N(N),
    .W(W)
  ) u_regfile (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_holeAddr (r_h),
    .i_keyAddr  (r_i),
    .i_rdAddr   (rd_addr),
    .o_prevData (w_prevData),
    .o_keyData  (w_keyData),
    .o_rdData   (rd_data)
  );

  // Strict greater-than keeps equal keys in their original order
  assign w_doShift = (r_h != '0) && (w_prevData > r_key);

  // The loader owns the write port only while idle; the FSM owns it while busy
  always_comb begin
    w_we    = 1'b0;
    w_waddr = load_addr;
    w_wdata = load_data;
    if (!r_busy) begin
      w_we = load_we;
    end else if (ce_step && r_state == COMPARE && w_doShift) begin
      w_we    = 1'b1;
      w_waddr = r_h;
      w_wdata = w_prevData;
    end else if (ce_step && r_state == INSERT) begin
      w_we    = 1'b1;
      w_waddr = r_h;
      w_wdata = r_key;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_h     <= '0;
      r_key   <= '0;
      r_cmp   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= INIT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_cmp   <= '0;
            r_shift <= '0;
          end
        end
        INIT: begin
          if (ce_step) begin
            r_i     <= IW'(1);
            r_state <= LOAD_KEY;
          end
        end
        LOAD_KEY: begin
          if (ce_step) begin
            r_key   <= w_keyData;
            r_h     <= r_i;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (ce_step) begin
            if (r_h == '0) begin
              r_state <= INSERT;
            end else begin
              r_cmp <= satInc(r_cmp);
              if (w_doShift) begin
                r_h     <= r_h - 1'b1;
                r_shift <= satInc(r_shift);
              end else begin
                r_state <= INSERT;
              end
            end
          end
        end
        INSERT: begin
          if (ce_step) begin
            if (r_i == IW'(N - 1)) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_i     <= r_i + 1'b1;
              r_state <= LOAD_KEY;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign key_idx     = r_i;
  assign hole_idx    = r_h;
  assign key         = r_key;
  assign cmp_count   = r_cmp;
  assign shift_count = r_shift;

endmodule
